// File: rtl/image_stream_receiver.sv
// Image stream receiver: assembles a byte stream into double-buffered 16x16 binary images.
// Define IMAGE_RX_CHECKSUM_EN to append and verify an XOR checksum byte per frame.
module image_stream_receiver #(
    parameter int BYTES_PER_IMAGE = 32
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid,
    input  logic [7:0]                               data_in,
    input  logic                                     sync,
    output logic [8*BYTES_PER_IMAGE-1:0]             image,
    output logic                                     image_valid,
    output logic [$clog2(BYTES_PER_IMAGE+1)-1:0]     byte_index,
    output logic [7:0]                               frame_count,
    output logic                                     rx_error
);

    localparam int IW = $clog2(BYTES_PER_IMAGE + 1);
    localparam int AW = 8 * BYTES_PER_IMAGE;
`ifdef IMAGE_RX_CHECKSUM_EN
    localparam int LAST = BYTES_PER_IMAGE;
`else
    localparam int LAST = BYTES_PER_IMAGE - 1;
`endif
    localparam logic [IW-1:0] LAST_IDX = IW'(LAST);

    logic [AW-1:0] r_acc;
    logic [AW-1:0] r_image;
    logic [IW-1:0] r_idx;
    logic [7:0]    r_fcnt;
    logic          r_valid;

    logic [AW-1:0] w_acc_wr;
    logic [AW-1:0] w_acc_nxt;
    logic [IW-1:0] w_idx_nxt;
    logic          w_last;
    logic          w_commit;

    // Accumulator with the incoming byte placed at the current position.
    always_comb begin
        w_acc_wr = r_acc;
        for (int i = 0; i < BYTES_PER_IMAGE; i++) begin
            if (r_idx == IW'(i)) begin
                w_acc_wr[8*i +: 8] = data_in;
            end
        end
    end

    // Sync outranks frame end, so a sync on the last byte never commits.
    assign w_last = in_valid && !sync && (r_idx == LAST_IDX);

`ifdef IMAGE_RX_CHECKSUM_EN
    logic [7:0] r_xor;
    logic [7:0] w_xor_nxt;
    logic       r_err;
    logic       w_sum_ok;

    assign w_sum_ok = (data_in == r_xor);
    assign w_commit = w_last && w_sum_ok;

    always_comb begin
        w_xor_nxt = r_xor;
        if (sync) begin
            w_xor_nxt = in_valid ? data_in : 8'h00;
        end else if (in_valid) begin
            w_xor_nxt = w_last ? 8'h00 : (r_xor ^ data_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xor <= 8'h00;
            r_err <= 1'b0;
        end else begin
            r_xor <= w_xor_nxt;
            r_err <= w_last && !w_sum_ok;
        end
    end

    assign rx_error = r_err;
`else
    assign w_commit = w_last;
    assign rx_error = 1'b0;
`endif

    always_comb begin
        w_acc_nxt = r_acc;
        w_idx_nxt = r_idx;
        if (sync) begin
            w_acc_nxt = in_valid ? AW'(data_in) : '0;
            w_idx_nxt = in_valid ? IW'(1) : '0;
        end else if (in_valid) begin
            w_acc_nxt = w_acc_wr;
            w_idx_nxt = w_last ? '0 : (r_idx + IW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_idx   <= '0;
            r_image <= '0;
            r_fcnt  <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            r_acc   <= w_acc_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_commit;
            if (w_commit) begin
                r_image <= w_acc_wr;
                r_fcnt  <= r_fcnt + 8'h01;
            end
        end
    end

    assign image       = r_image;
    assign image_valid = r_valid;
    assign byte_index  = r_idx;
    assign frame_count = r_fcnt;

endmodule

// File: tb/tb_image_stream_receiver.sv
// Self-checking bench for image_stream_receiver: vector table plus scoreboard.
// Frames gain an XOR checksum byte when IMAGE_RX_CHECKSUM_EN is defined.
module tb_image_stream_receiver;

    localparam int BPI = 32;
    localparam int IW  = $clog2(BPI + 1);
    localparam int AW  = 8 * BPI;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [7:0]    data_in;
    logic          sync;
    logic [AW-1:0] image;
    logic          image_valid;
    logic [IW-1:0] byte_index;
    logic [7:0]    frame_count;
    logic          rx_error;

    image_stream_receiver #(.BYTES_PER_IMAGE(BPI)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .sync       (sync),
        .image      (image),
        .image_valid(image_valid),
        .byte_index (byte_index),
        .frame_count(frame_count),
        .rx_error   (rx_error)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            pulses  = 0;
    int            err_pending = 0;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] last_img;
    logic [7:0]    exp_fc;
    logic [7:0]    frm [BPI];

    function automatic void chk(input string nm,
                                input logic [AW-1:0] act,
                                input logic [AW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endfunction

    // Scoreboard: every commit pops one expected image.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_img = '0;
            exp_fc   = 8'h00;
        end else begin
            if (image_valid) begin
                pulses++;
                exp_fc = exp_fc + 8'h01;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    chk("image", image, exp_q.pop_front());
                end
                chk("frame_count", AW'(frame_count), AW'(exp_fc));
                last_img = image;
            end else begin
                chk("image_stable", image, last_img);
            end
            if (rx_error) begin
                if (err_pending > 0) err_pending--;
                else chk("unexpected_rx_error", 1, 0);
            end
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic s);
        @(negedge clk);
        in_valid = v;
        data_in  = d;
        sync     = s;
    endtask

    task automatic send_frame(input int gapmax, input bit sync_first,
                              input bit corrupt);
        logic [AW-1:0] img;
        logic [7:0]    x;
        int            g;
        x = 8'h00;
        for (int i = 0; i < BPI; i++) begin
            img[8*i +: 8] = frm[i];
            x = x ^ frm[i];
        end
`ifdef IMAGE_RX_CHECKSUM_EN
        if (corrupt) err_pending++;
        else exp_q.push_back(img);
`else
        exp_q.push_back(img);
`endif
        for (int i = 0; i < BPI; i++) begin
            g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            for (int k = 0; k < g; k++) begin
                @(negedge clk);
                if (i > 0) chk("idx_gap", AW'(byte_index), AW'(i));
                in_valid = 1'b0;
                sync     = 1'b0;
                data_in  = 8'($urandom);
            end
            @(negedge clk);
            if (i > 0) chk("idx", AW'(byte_index), AW'(i));
            rst_n    = 1'b1;
            in_valid = 1'b1;
            data_in  = frm[i];
            sync     = (i == 0) && sync_first;
        end
`ifdef IMAGE_RX_CHECKSUM_EN
        @(negedge clk);
        chk("idx_sum", AW'(byte_index), AW'(BPI));
        data_in = x ^ (corrupt ? 8'h01 : 8'h00);
`endif
        @(negedge clk);
        in_valid = 1'b0;
        sync     = 1'b0;
        chk("idx_end", AW'(byte_index), 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && (exp_q.size() != 0 || err_pending != 0); k++)
            @(negedge clk);
        chk("drain", AW'(exp_q.size() + err_pending), 0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_image"}, image, '0);
        chk({nm, "_valid"}, AW'(image_valid), 0);
        chk({nm, "_idx"}, AW'(byte_index), 0);
        chk({nm, "_fc"}, AW'(frame_count), 0);
        chk({nm, "_err"}, AW'(rx_error), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sync     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
    endtask

    typedef struct {
        logic [7:0] base;
        logic [7:0] step;
        int         gapmax;
        logic [7:0] exp_b0;
        logic [7:0] exp_blast;
    } vec_t;

    vec_t          vecs [5];
    int            p0;
    logic [AW-1:0] saved;
    logic [7:0]    fc0;

    initial begin
        vecs[0] = '{8'h00, 8'h01, 0, 8'h00, 8'h1F};
        vecs[1] = '{8'h00, 8'h01, 5, 8'h00, 8'h1F};
        vecs[2] = '{8'h80, 8'h03, 2, 8'h80, 8'hDD};
        vecs[3] = '{8'hFF, 8'hFF, 1, 8'hFF, 8'hE0};
        vecs[4] = '{8'h55, 8'h00, 3, 8'h55, 8'h55};

        rst_n = 1'b0; in_valid = 1'b0; data_in = 8'h00; sync = 1'b0;
        apply_reset();

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < BPI; i++)
                frm[i] = vecs[v].base + 8'(vecs[v].step * i);
            p0 = pulses;
            send_frame(vecs[v].gapmax, 1'b0, 1'b0);
            drain();
            chk("vec_pulses", AW'(pulses - p0), 1);
            chk("vec_b0", AW'(image[7:0]), AW'(vecs[v].exp_b0));
            chk("vec_blast", AW'(image[AW-1 -: 8]), AW'(vecs[v].exp_blast));
        end
        chk("fc_after_table", AW'(frame_count), 5);

        // 20 stale bytes, then a sync-started frame replaces them.
        p0 = pulses;
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0);
        frm[0] = 8'hAA;
        for (int i = 1; i < BPI; i++) frm[i] = 8'h40 + 8'(i);
        send_frame(0, 1'b1, 1'b0);
        drain();
        chk("sync_pulses", AW'(pulses - p0), 1);
        chk("sync_b0", AW'(image[7:0]), 8'hAA);
        chk("sync_b19", AW'(image[8*19 +: 8]), 8'h53);

        // Idle sync clears a partial frame.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(i), 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("sync_idle_idx", AW'(byte_index), 0);

        // Sync on the would-be last byte commits nothing.
        p0 = pulses;
        saved = image;
        for (int i = 0; i < BPI - 1; i++) cyc(1'b1, 8'(i), 1'b0);
`ifdef IMAGE_RX_CHECKSUM_EN
        cyc(1'b1, 8'h00, 1'b0);
`endif
        cyc(1'b1, 8'h77, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("sync_last_idx", AW'(byte_index), 1);
        chk("sync_last_pulses", AW'(pulses - p0), 0);
        chk("sync_last_image", image, saved);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);

        // Reset mid-frame; first byte accepted on the release edge.
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'hC0 + 8'(i), 1'b0);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        for (int i = 0; i < BPI; i++) frm[i] = 8'(i * 7 + 3);
        send_frame(0, 1'b0, 1'b0);
        drain();
        chk("midrst_fc", AW'(frame_count), 1);
        chk("midrst_b9", AW'(image[8*9 +: 8]), AW'(8'd66));

        // 256 frames wrap the counter back to 0.
        apply_reset();
        p0 = pulses;
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < BPI; i++) frm[i] = 8'($urandom);
            send_frame(0, 1'b0, 1'b0);
        end
        drain();
        chk("wrap_pulses", AW'(pulses - p0), 256);
        chk("wrap_fc", AW'(frame_count), 0);

`ifdef IMAGE_RX_CHECKSUM_EN
        for (int i = 0; i < BPI; i++) frm[i] = 8'hA0 ^ 8'(i);
        p0 = pulses;
        send_frame(2, 1'b0, 1'b0);
        drain();
        chk("sum_ok_pulses", AW'(pulses - p0), 1);
        saved = image;
        fc0 = frame_count;
        for (int i = 0; i < BPI; i++) frm[i] = 8'(i * 5);
        send_frame(0, 1'b0, 1'b1);
        drain();
        chk("sum_bad_image", image, saved);
        chk("sum_bad_fc", AW'(frame_count), AW'(fc0));
        chk("sum_bad_pulses", AW'(pulses - p0), 1);
`else
        fc0 = frame_count;
        chk("no_sum_err", AW'(rx_error), 0);
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
